// File: rtl/scope_filter_mc.sv
// Multi-lane FIR -> IIR1 -> IIR2 -> scale/sat equaliser, 5-stage valid/ready pipe.
// SCOPE_FILTER_MC_SAT_CNT_EN builds the per-lane saturation counters.
module scope_filter_mc #(
  parameter int CN  = 2,
  parameter int DWI = 16,
  parameter int DWO = 14
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [CN*18-1:0]  cfg_aa,
  input  logic [CN*25-1:0]  cfg_bb,
  input  logic [CN*25-1:0]  cfg_pp,
  input  logic [CN*25-1:0]  cfg_kk,
  input  logic [CN-1:0]     cfg_byp,
  input  logic              cfg_upd,
  input  logic              ctl_rst,
  input  logic              sts_clr,
  input  logic [CN*DWI-1:0] sti_tdata,
  input  logic              sti_tvalid,
  output logic              sti_tready,
  output logic [CN*DWO-1:0] sto_tdata,
  output logic              sto_tvalid,
  input  logic              sto_tready,
  output logic [CN-1:0]     sts_sat,
  output logic [CN*16-1:0]  sts_sat_cnt
);

  localparam int W1 = DWI + 8;
  localparam int PW = DWI + 30;
  localparam int SW = DWI + 31;
  localparam int QW = W1 + 27;
  localparam int MW = DWI + 25;
  localparam logic [DWO-1:0] YMAX = {1'b0, {(DWO-1){1'b1}}};
  localparam logic [DWO-1:0] YMIN = {1'b1, {(DWO-1){1'b0}}};

  logic [CN*18-1:0] r_aa;
  logic [CN*25-1:0] r_bb;
  logic [CN*25-1:0] r_pp;
  logic [CN*25-1:0] r_kk;
  logic [CN-1:0]    r_byp;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_aa  <= '0;
      r_bb  <= '0;
      r_pp  <= '0;
      r_kk  <= '0;
      r_byp <= '1;
    end else if (cfg_upd) begin
      r_aa  <= cfg_aa;
      r_bb  <= cfg_bb;
      r_pp  <= cfg_pp;
      r_kk  <= cfg_kk;
      r_byp <= cfg_byp;
    end
  end

  logic [5:1] r_vld;
  logic [5:1] w_rdy;
  logic [5:1] w_acc;

  // Closed form of ready_k = ready_{k+1} | ~valid_k, no chained nets.
  for (genvar k = 1; k <= 5; k++) begin : g_rdy
    assign w_rdy[k] = sto_tready | ~(&r_vld[5:k]);
    if (k == 1) begin : g_a1
      assign w_acc[k] = sti_tvalid & sti_tready;
    end else begin : g_ak
      assign w_acc[k] = r_vld[k-1] & w_rdy[k];
    end
  end

  assign sti_tready = w_rdy[1] & ~ctl_rst;
  assign sto_tvalid = r_vld[5];

  always_ff @(posedge ACLK) begin
    if (!ARESETn || ctl_rst) begin
      r_vld <= '0;
    end else begin
      if (w_rdy[1]) r_vld[1] <= sti_tvalid;
      for (int k = 2; k <= 5; k++)
        if (w_rdy[k]) r_vld[k] <= r_vld[k-1];
    end
  end

  for (genvar c = 0; c < CN; c++) begin : g_ln
    logic signed [DWI-1:0] w_x;
    logic signed [17:0]    w_aa;
    logic signed [24:0]    w_bb;
    logic signed [24:0]    w_pp;
    logic signed [24:0]    w_kk;
    logic                  w_byp;
    logic                  w_clr;

    assign w_x   = sti_tdata[c*DWI +: DWI];
    assign w_aa  = r_aa[c*18 +: 18];
    assign w_bb  = r_bb[c*25 +: 25];
    assign w_pp  = r_pp[c*25 +: 25];
    assign w_kk  = r_kk[c*25 +: 25];
    assign w_byp = r_byp[c];
    assign w_clr = !ARESETn || ctl_rst || w_byp;

    logic signed [DWI-1:0] r_xp;
    logic signed [W1-1:0]  r_u1;
    logic signed [DWI-1:0] r_v1;
    logic signed [DWI-1:0] r_x1, r_x2, r_x3, r_x4;
    logic signed [PW-1:0]  r_p1;
    logic signed [W1-1:0]  r_f2;
    logic signed [W1-1:0]  r_u3;
    logic signed [DWI-1:0] r_v4;
    logic [DWO-1:0]        r_y;
    logic                  r_sat;

    logic signed [29:0]    w_bm;
    logic signed [PW-1:0]  w_p1;
    logic signed [SW-1:0]  w_sum;
    logic signed [W1-1:0]  w_f;
    logic signed [26:0]    w_ma;
    logic signed [QW-1:0]  w_q1;
    logic signed [W1-1:0]  w_u;
    logic signed [MW-1:0]  w_q2;
    logic signed [DWI-1:0] w_v;
    logic signed [MW-1:0]  w_q3;
    logic signed [DWI:0]   w_s;
    logic [DWI-DWO+1:0]    w_hi;
    logic                  w_sat;
    logic [DWO-1:0]        w_ys;
    logic [DWO-1:0]        w_y;
    logic                  w_evt;

    // x[n]*2^28 + x[n-1]*(bb-2^28): unity tap plus a difference term
    assign w_bm  = 30'(w_bb) - 30'sd268435456;
    assign w_p1  = PW'(r_xp) * PW'(w_bm);
    assign w_sum = SW'($signed({r_x1, 28'd0})) + SW'(r_p1);
    assign w_f   = W1'(w_sum >>> 20);
    assign w_ma  = 27'sd33554432 - 27'(w_aa);
    assign w_q1  = QW'(r_u1) * QW'(w_ma);
    assign w_u   = r_f2 + W1'(w_q1 >>> 25);
    assign w_q2  = MW'(r_v1) * MW'(w_pp);
    assign w_v   = DWI'(r_u3 >>> 8) + DWI'(w_q2 >>> 16);
    assign w_q3  = MW'(r_v4) * MW'(w_kk);
    assign w_s   = (DWI+1)'(w_q3 >>> 24);
    assign w_hi  = w_s[DWI:DWO-1];
    assign w_sat = ~((&w_hi) | ~(|w_hi));
    assign w_ys  = w_sat ? (w_s[DWI] ? YMIN : YMAX) : w_s[DWO-1:0];
    assign w_y   = w_byp ? DWO'(r_x4 >>> (DWI-DWO)) : w_ys;
    assign w_evt = w_acc[5] & ~ctl_rst & ~w_byp & w_sat;

    always_ff @(posedge ACLK) begin
      if (w_clr) begin
        r_xp <= '0;
        r_u1 <= '0;
        r_v1 <= '0;
      end else begin
        if (w_acc[1]) r_xp <= w_x;
        if (w_acc[3]) r_u1 <= w_u;
        if (w_acc[4]) r_v1 <= w_v;
      end
    end

    always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
        r_x1 <= '0;
        r_p1 <= '0;
        r_x2 <= '0;
        r_f2 <= '0;
        r_x3 <= '0;
        r_u3 <= '0;
        r_x4 <= '0;
        r_v4 <= '0;
        r_y  <= '0;
      end else begin
        if (w_acc[1]) begin
          r_x1 <= w_x;
          r_p1 <= w_p1;
        end
        if (w_acc[2]) begin
          r_x2 <= r_x1;
          r_f2 <= w_f;
        end
        if (w_acc[3]) begin
          r_x3 <= r_x2;
          r_u3 <= w_u;
        end
        if (w_acc[4]) begin
          r_x4 <= r_x3;
          r_v4 <= w_v;
        end
        if (w_acc[5]) r_y <= w_y;
      end
    end

    always_ff @(posedge ACLK) begin
      if (!ARESETn)     r_sat <= 1'b0;
      else if (w_evt)   r_sat <= 1'b1;
      else if (sts_clr) r_sat <= 1'b0;
    end

    assign sto_tdata[c*DWO +: DWO] = r_y;
    assign sts_sat[c] = r_sat;

`ifdef SCOPE_FILTER_MC_SAT_CNT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge ACLK) begin
      if (!ARESETn)
        r_cnt <= '0;
      else if (w_evt)
        r_cnt <= sts_clr ? 16'd1 : (&r_cnt ? r_cnt : r_cnt + 16'd1);
      else if (sts_clr)
        r_cnt <= '0;
    end

    assign sts_sat_cnt[c*16 +: 16] = r_cnt;
`else
    assign sts_sat_cnt[c*16 +: 16] = 16'd0;
`endif
  end

endmodule

// File: tb/tb_scope_filter_mc.sv
// Directed bench for scope_filter_mc: reset, identity, saturation,
// bypass, backpressure and filter clear.
module tb_scope_filter_mc;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [35:0] cfg_aa;
  logic [49:0] cfg_bb;
  logic [49:0] cfg_pp;
  logic [49:0] cfg_kk;
  logic [1:0]  cfg_byp;
  logic        cfg_upd;
  logic        ctl_rst;
  logic        sts_clr;
  logic [31:0] sti_tdata;
  logic        sti_tvalid;
  logic        sti_tready;
  logic [27:0] sto_tdata;
  logic        sto_tvalid;
  logic        sto_tready;
  logic [1:0]  sts_sat;
  logic [31:0] sts_sat_cnt;

  logic signed [13:0] y0, y1;
  assign y0 = sto_tdata[13:0];
  assign y1 = sto_tdata[27:14];

  int n_chk = 0;
  int n_fail = 0;

`ifdef SCOPE_FILTER_MC_SAT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  scope_filter_mc #(.CN(2), .DWI(16), .DWO(14)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cfg_aa(cfg_aa), .cfg_bb(cfg_bb), .cfg_pp(cfg_pp),
    .cfg_kk(cfg_kk), .cfg_byp(cfg_byp), .cfg_upd(cfg_upd),
    .ctl_rst(ctl_rst), .sts_clr(sts_clr),
    .sti_tdata(sti_tdata), .sti_tvalid(sti_tvalid),
    .sti_tready(sti_tready),
    .sto_tdata(sto_tdata), .sto_tvalid(sto_tvalid),
    .sto_tready(sto_tready),
    .sts_sat(sts_sat), .sts_sat_cnt(sts_sat_cnt)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  // Identity-config reference: u = 256x, v = x, s = floor(x/2), clamped.
  function automatic int model(input int x);
    int s;
    s = x >>> 1;
    if (s > 8191) s = 8191;
    if (s < -8192) s = -8192;
    return s;
  endfunction

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] byp,
                         input logic [24:0] k0,
                         input logic [24:0] k1);
    cfg_aa  = '0;
    cfg_bb  = '0;
    cfg_pp  = '0;
    cfg_kk  = {k1, k0};
    cfg_byp = byp;
    cfg_upd = 1'b1;
    tick();
    cfg_upd = 1'b0;
  endtask

  task automatic clr_state;
    ctl_rst = 1'b1;
    tick();
    ctl_rst = 1'b0;
  endtask

  task automatic pulse_sts_clr;
    sts_clr = 1'b1;
    tick();
    sts_clr = 1'b0;
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    tick();
    tick();
    n_chk++;
    if (sto_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_vld: got %b want 0", sto_tvalid);
    end
    n_chk++;
    if (sto_tdata !== 28'd0) begin
      n_fail++;
      $display("FAIL rst_data: got %h want 0", sto_tdata);
    end
    n_chk++;
    if (sts_sat !== 2'b00 || sts_sat_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_sts: got %b/%h want 0/0", sts_sat, sts_sat_cnt);
    end
    ARESETn = 1'b1;
    tick();
    n_chk++;
    if (sti_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rdy: got %b want 1", sti_tready);
    end
    sti_tdata  = {16'sd0, 16'sd4000};
    sti_tvalid = 1'b1;
    tick();
    sti_tvalid = 1'b0;
    for (int k = 0; k < 10 && !sto_tvalid; k++) tick();
    n_chk++;
    if (sto_tvalid !== 1'b1 || y0 !== 14'sd1000 || y1 !== 14'sd0) begin
      n_fail++;
      $display("FAIL rst_byp: got v=%b %0d/%0d want 1 1000/0",
               sto_tvalid, y0, y1);
    end
    repeat (4) tick();
  endtask

  task automatic test_identity;
    int xa0[12];
    int xa1[12];
    set_cfg(2'b00, 25'h0800000, 25'h0800000);
    clr_state();
    for (int i = 0; i < 12; i++) begin
      xa0[i] = (i < 3) ? 0 : 1000;
      xa1[i] = -7 * i;
    end
    for (int i = 0; i < 12; i++) begin
      sti_tdata  = {16'(xa1[i]), 16'(xa0[i])};
      sti_tvalid = 1'b1;
      tick();
      n_chk++;
      if (i < 4) begin
        if (sto_tvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL id_lat[%0d]: got vld %b want 0", i, sto_tvalid);
        end
      end else if (sto_tvalid !== 1'b1 || int'(y0) != model(xa0[i-4])
                   || int'(y1) != model(xa1[i-4])) begin
        n_fail++;
        $display("FAIL id_out[%0d]: got v=%b %0d/%0d want 1 %0d/%0d",
                 i, sto_tvalid, y0, y1,
                 model(xa0[i-4]), model(xa1[i-4]));
      end
    end
    sti_tvalid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_saturation;
    int xa1[8];
    pulse_sts_clr();
    clr_state();
    for (int i = 0; i < 8; i++) xa1[i] = (i < 3) ? 20000 : 0;
    for (int i = 0; i < 8; i++) begin
      sti_tdata  = {16'(xa1[i]), 16'd0};
      sti_tvalid = 1'b1;
      tick();
      if (i >= 4) begin
        n_chk++;
        if (sto_tvalid !== 1'b1 || int'(y1) != model(xa1[i-4])
            || y0 !== 14'sd0) begin
          n_fail++;
          $display("FAIL sat_out[%0d]: got v=%b %0d/%0d want 1 0/%0d",
                   i, sto_tvalid, y0, y1, model(xa1[i-4]));
        end
      end
    end
    sti_tvalid = 1'b0;
    repeat (6) tick();
    n_chk++;
    if (sts_sat !== 2'b10) begin
      n_fail++;
      $display("FAIL sat_flag: got %b want 10", sts_sat);
    end
    n_chk++;
    if (sts_sat_cnt !== (CNT_EN ? {16'd3, 16'd0} : 32'd0)) begin
      n_fail++;
      $display("FAIL sat_cnt3: got %h want %h", sts_sat_cnt,
               CNT_EN ? {16'd3, 16'd0} : 32'd0);
    end
    // saturating beat reaches stage 5 on the same edge as sts_clr
    for (int e = 0; e < 6; e++) begin
      sti_tdata  = {16'sd20000, 16'd0};
      sti_tvalid = (e == 0);
      sts_clr    = (e == 4);
      tick();
    end
    sts_clr = 1'b0;
    n_chk++;
    if (sts_sat !== 2'b10 || y1 !== 14'sd8191) begin
      n_fail++;
      $display("FAIL sat_race_flag: got %b y1=%0d want 10 8191",
               sts_sat, y1);
    end
    n_chk++;
    if (sts_sat_cnt !== (CNT_EN ? {16'd1, 16'd0} : 32'd0)) begin
      n_fail++;
      $display("FAIL sat_race_cnt: got %h want %h", sts_sat_cnt,
               CNT_EN ? {16'd1, 16'd0} : 32'd0);
    end
    pulse_sts_clr();
    n_chk++;
    if (sts_sat !== 2'b00 || sts_sat_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL sat_clr: got %b/%h want 00/0", sts_sat, sts_sat_cnt);
    end
  endtask

  task automatic test_neg_sat;
    int xa0[8];
    clr_state();
    for (int i = 0; i < 8; i++) xa0[i] = (i < 3) ? -20000 : 0;
    for (int i = 0; i < 8; i++) begin
      sti_tdata  = {16'd0, 16'(xa0[i])};
      sti_tvalid = 1'b1;
      tick();
      if (i >= 4) begin
        n_chk++;
        if (sto_tvalid !== 1'b1 || int'(y0) != model(xa0[i-4])) begin
          n_fail++;
          $display("FAIL neg_out[%0d]: got v=%b %0d want 1 %0d",
                   i, sto_tvalid, y0, model(xa0[i-4]));
        end
      end
    end
    sti_tvalid = 1'b0;
    repeat (6) tick();
    n_chk++;
    if (sts_sat !== 2'b01) begin
      n_fail++;
      $display("FAIL neg_flag: got %b want 01", sts_sat);
    end
  endtask

  task automatic test_bypass;
    int lat;
    pulse_sts_clr();
    set_cfg(2'b01, 25'h0800000, 25'h0800000);
    clr_state();
    sti_tdata  = {16'sd1000, 16'h8000};
    sti_tvalid = 1'b1;
    tick();
    sti_tvalid = 1'b0;
    lat = 1;
    while (!sto_tvalid && lat < 20) begin
      tick();
      lat++;
    end
    n_chk++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL byp_lat: got %0d want 5", lat);
    end
    n_chk++;
    if (y0 !== -14'sd8192 || y1 !== 14'sd500) begin
      n_fail++;
      $display("FAIL byp_out: got %0d/%0d want -8192/500", y0, y1);
    end
    repeat (3) tick();
    n_chk++;
    if (sts_sat !== 2'b00) begin
      n_fail++;
      $display("FAIL byp_sat: got %b want 00", sts_sat);
    end
  endtask

  task automatic test_backpressure;
    int idx;
    int oidx;
    bit acc_in;
    bit acc_out;
    bit held;
    bit saw_stall;
    logic [27:0] hold_d;
    set_cfg(2'b00, 25'h0800000, 25'h0800000);
    clr_state();
    idx = 0;
    oidx = 0;
    held = 1'b0;
    saw_stall = 1'b0;
    hold_d = '0;
    for (int cyc = 0; cyc < 200 && oidx < 20; cyc++) begin
      sto_tready = !(cyc >= 3 && cyc <= 12);
      sti_tvalid = (idx < 20);
      sti_tdata  = {16'(-3 * idx), 16'(idx)};
      #1;
      n_chk++;
      if (sti_tready !== (sto_tready || (idx - oidx) < 5)) begin
        n_fail++;
        $display("FAIL bp_rdy[%0d]: got %b want %b (inflight %0d)",
                 cyc, sti_tready, !sti_tready, idx - oidx);
      end
      if (!sti_tready) saw_stall = 1'b1;
      if (held) begin
        n_chk++;
        if (sto_tdata !== hold_d) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: got %h want %h",
                   cyc, sto_tdata, hold_d);
        end
      end
      held    = sto_tvalid & ~sto_tready;
      hold_d  = sto_tdata;
      acc_in  = sti_tvalid & sti_tready;
      acc_out = sto_tvalid & sto_tready;
      if (acc_out) begin
        n_chk++;
        if (int'(y0) != model(oidx) || int'(y1) != model(-3 * oidx)) begin
          n_fail++;
          $display("FAIL bp_out[%0d]: got %0d/%0d want %0d/%0d",
                   oidx, y0, y1, model(oidx), model(-3 * oidx));
        end
        oidx++;
      end
      if (acc_in) idx++;
      tick();
    end
    sti_tvalid = 1'b0;
    sto_tready = 1'b1;
    n_chk++;
    if (oidx != 20 || !saw_stall) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats stall=%b want 20 1",
               oidx, saw_stall);
    end
    repeat (3) tick();
  endtask

  task automatic test_ctl_rst;
    set_cfg(2'b00, 25'h0800000, 25'h0800000);
    clr_state();
    for (int i = 0; i < 3; i++) begin
      sti_tdata  = {16'd0, 16'sd3000};
      sti_tvalid = 1'b1;
      tick();
    end
    sti_tvalid = 1'b0;
    ctl_rst = 1'b1;
    cfg_kk  = {25'h0400000, 25'h0800000};
    cfg_upd = 1'b1;
    #1;
    n_chk++;
    if (sti_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL crst_rdy: got %b want 0", sti_tready);
    end
    tick();
    ctl_rst = 1'b0;
    cfg_upd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_chk++;
      if (sto_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL crst_vld[%0d]: got %b want 0", k, sto_tvalid);
      end
      tick();
    end
    sti_tdata  = {16'sd1000, 16'sd1000};
    sti_tvalid = 1'b1;
    tick();
    sti_tvalid = 1'b0;
    for (int k = 0; k < 10 && !sto_tvalid; k++) tick();
    n_chk++;
    if (sto_tvalid !== 1'b1 || y0 !== 14'sd500 || y1 !== 14'sd250) begin
      n_fail++;
      $display("FAIL crst_out: got v=%b %0d/%0d want 1 500/250",
               sto_tvalid, y0, y1);
    end
    repeat (3) tick();
  endtask

  initial begin
    ARESETn    = 1'b0;
    cfg_aa     = '0;
    cfg_bb     = '0;
    cfg_pp     = '0;
    cfg_kk     = '0;
    cfg_byp    = '0;
    cfg_upd    = 1'b0;
    ctl_rst    = 1'b0;
    sts_clr    = 1'b0;
    sti_tdata  = '0;
    sti_tvalid = 1'b0;
    sto_tready = 1'b1;
    test_reset();
    test_identity();
    test_saturation();
    test_neg_sat();
    test_bypass();
    test_backpressure();
    test_ctl_rst();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
